// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    STALL = 2'd2,
    BURST = 2'd3
  } fifo_arb_state_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_FIFO_WIDTH = 16;
  localparam int ID_W           = $clog2(DEF_NUM_REQ);

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: the first active request at or after
// ptr wins, and the search wraps from N-1 back to 0.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int N = DEF_NUM_REQ,
  parameter int W = ID_W
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] winner
);

  int idx;

  // Scan offsets from the far end down, so the nearest request to ptr is the last one written.
  always_comb begin
    any    = |req;
    winner = '0;
    idx    = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) winner = idx[W-1:0];
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port among NUM_REQ
// requesters, with flow control from full/almostfull so no grant can overflow.
// Optional burst ownership is enabled by defining FIFO_ARB_BURST_EN.
//
//   state | meaning
//   IDLE  | no request pending
//   GRANT | may issue a grant this cycle (gated by the current FIFO flags)
//   STALL | requests pending but the FIFO is blocked, no grant
//   BURST | current owner may keep the port (burst build only)
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int MAX_BURST  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0]   data,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]           fifo_data_in,
  input  logic                            fifo_full,
  input  logic                            fifo_almostfull,
  input  logic                            fifo_overflow,
  output logic                            err_overflow,
  output logic                            busy
);

  localparam int GID_W  = $clog2(NUM_REQ);
  localparam int BCNT_W = $clog2(MAX_BURST + 1);

`ifdef FIFO_ARB_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  fifo_arb_state_t    state, state_nxt;
  logic [GID_W-1:0]   ptr, pick_id, win_id;
  logic               pick_any, allowed, grant_state, burst_cont, do_grant;
  logic [BCNT_W-1:0]  burst_cnt;

  rr_picker #(
    .N (NUM_REQ),
    .W (GID_W)
  ) u_picker (
    .req    (req),
    .ptr    (ptr),
    .any    (pick_any),
    .winner (pick_id)
  );

  // A write already in flight into the last free slot blocks new grants.
  assign allowed     = !fifo_full && !(fifo_almostfull && fifo_wr_en);
  assign grant_state = (state == GRANT) || (state == BURST);
  // ptr already points past the owner, so when a burst ends the picker
  // naturally resumes the search just after it.
  assign burst_cont  = BURST_EN && (state == BURST) && req[grant_id] &&
                       (burst_cnt < BCNT_W'(MAX_BURST));
  assign win_id      = burst_cont ? grant_id : pick_id;
  // Grant uses this cycle's flags, so the decision always sees the latest FIFO level.
  assign do_grant    = !rst && grant_state && allowed && (burst_cont || pick_any);
  assign busy        = (state != IDLE);

  // One-hot grant pulse for the winning requester.
  always_comb begin
    gnt = '0;
    if (do_grant) gnt[win_id] = 1'b1;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, STALL: begin
        if (pick_any && allowed) state_nxt = GRANT;
        else if (pick_any)       state_nxt = STALL;
        else                     state_nxt = IDLE;
      end
      GRANT, BURST: begin
        if (pick_any && allowed) state_nxt = BURST_EN ? BURST : GRANT;
        else if (pick_any)       state_nxt = STALL;
        else                     state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, pointer, burst count and registered FIFO write side.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      grant_id     <= '0;
      burst_cnt    <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_data_in <= '0;
    end else begin
      state      <= state_nxt;
      fifo_wr_en <= do_grant;
      if (do_grant) begin
        grant_id     <= win_id;
        fifo_data_in <= data[int'(win_id)*FIFO_WIDTH +: FIFO_WIDTH];
        ptr          <= (int'(win_id) == NUM_REQ - 1) ? '0 : win_id + GID_W'(1);
        burst_cnt    <= burst_cont ? burst_cnt + BCNT_W'(1) : BCNT_W'(1);
      end
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)                err_overflow <= 1'b0;
    else if (fifo_overflow) err_overflow <= 1'b1;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a small 8-deep FIFO level model.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] data;
  logic [3:0]  gnt;
  logic [1:0]  grant_id;
  logic        fifo_wr_en;
  logic [15:0] fifo_data_in;
  logic        fifo_full, fifo_almostfull, fifo_overflow;
  logic        err_overflow, busy;

  logic        rd_en, fifo_clr, force_ovf, model_ovf, ovf_seen;
  int          fcnt;
  int          checks = 0;
  int          errors = 0;
  int          ngnt, nwr;
  logic [15:0] slv [4] = '{16'h1110, 16'h2221, 16'h3332, 16'h4443};

  always #5 clk = ~clk;

  fifo_wr_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .data            (data),
    .gnt             (gnt),
    .grant_id        (grant_id),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_data_in    (fifo_data_in),
    .fifo_full       (fifo_full),
    .fifo_almostfull (fifo_almostfull),
    .fifo_overflow   (fifo_overflow),
    .err_overflow    (err_overflow),
    .busy            (busy)
  );

  assign fifo_full       = (fcnt == 8);
  assign fifo_almostfull = (fcnt == 7);
  assign model_ovf       = fifo_wr_en && fifo_full && !rd_en;
  assign fifo_overflow   = model_ovf || force_ovf;

  always @(posedge clk) begin
    if (fifo_clr) begin
      fcnt     <= 0;
      ovf_seen <= 1'b0;
    end else begin
      fcnt <= fcnt + ((fifo_wr_en && !model_ovf) ? 1 : 0) - ((rd_en && fcnt > 0) ? 1 : 0);
      if (model_ovf) ovf_seen <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 4'b1111; rd_en = 1'b1; fifo_clr = 1'b1; force_ovf = 1'b0;
    data = {slv[3], slv[2], slv[1], slv[0]};

    // reset held with all requests active
    nxt(); smp();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'h0);
    chk("rst_grant_id", 32'(grant_id), 32'h0);
    chk("rst_data_in", 32'(fifo_data_in), 32'h0);
    chk("rst_err", 32'(err_overflow), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    nxt(); smp();
    chk("rst_gnt_hold", 32'(gnt), 32'h0);
    chk("rst_wr_hold", 32'(fifo_wr_en), 32'h0);
    nxt(); rst = 1'b0; fifo_clr = 1'b0;
    smp();
    chk("post_rst_no_gnt_yet", 32'(gnt), 32'h0);
    nxt();

    // fairness with FIFO drained every cycle
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("rr_gnt", 32'(gnt), 32'(1 << (k % 4)));
      chk("rr_busy", 32'(busy), 32'h1);
      if (k > 0) begin
        chk("rr_wr_en", 32'(fifo_wr_en), 32'h1);
        chk("rr_data", 32'(fifo_data_in), 32'(slv[(k - 1) % 4]));
        chk("rr_grant_id", 32'(grant_id), 32'((k - 1) % 4));
      end
      nxt();
    end

    // backpressure: no reads, exactly 8 writes then stall
    req = 4'b0000;
    nxt(); nxt(); nxt();
    fifo_clr = 1'b1;
    nxt();
    fifo_clr = 1'b0; rd_en = 1'b0; req = 4'b1111;
    ngnt = 0; nwr = 0;
    for (int c = 0; c < 20; c++) begin
      smp();
      if (gnt != 4'b0000) ngnt++;
      if (fifo_wr_en) nwr++;
      nxt();
    end
    smp();
    chk("bp_grants", 32'(ngnt), 32'd8);
    chk("bp_writes", 32'(nwr), 32'd8);
    chk("bp_stall_gnt", 32'(gnt), 32'h0);
    chk("bp_stall_busy", 32'(busy), 32'h1);
    chk("bp_level", 32'(fcnt), 32'd8);
    chk("bp_no_overflow", 32'(ovf_seen), 32'h0);
    chk("bp_err", 32'(err_overflow), 32'h0);

    // reset out of STALL
    nxt();
    rst = 1'b1; fifo_clr = 1'b1; rd_en = 1'b1; req = 4'b0000;
    nxt();
    rst = 1'b0; fifo_clr = 1'b0; req = 4'b0100;
    smp();
    chk("rst2_busy", 32'(busy), 32'h0);
    chk("rst2_wr_en", 32'(fifo_wr_en), 32'h0);
    chk("rst2_gnt", 32'(gnt), 32'h0);

    // wrap-around and withdrawn request
    nxt(); smp();
    chk("wrap_gnt2", 32'(gnt), 32'h4);
    nxt(); req = 4'b0101; smp();
    chk("wrap_gnt0", 32'(gnt), 32'h1);
    chk("wrap_data2", 32'(fifo_data_in), 32'(slv[2]));
    nxt(); req = 4'b0100; smp();
    chk("wrap_gnt2b", 32'(gnt), 32'h4);
    chk("wrap_data0", 32'(fifo_data_in), 32'(slv[0]));
    chk("wrap_id0", 32'(grant_id), 32'h0);
    nxt(); req = 4'b0101; smp();
    chk("wd_gnt0", 32'(gnt), 32'h1);
    chk("wd_data2", 32'(fifo_data_in), 32'(slv[2]));
    nxt(); req = 4'b0000; smp();
    chk("wd_no_gnt", 32'(gnt), 32'h0);
    chk("wd_wr0", 32'(fifo_wr_en), 32'h1);
    chk("wd_data0", 32'(fifo_data_in), 32'(slv[0]));
    nxt(); smp();
    chk("wd_no_write", 32'(fifo_wr_en), 32'h0);
    chk("wd_data_hold", 32'(fifo_data_in), 32'(slv[0]));
    chk("wd_id_hold", 32'(grant_id), 32'h0);
    chk("wd_idle", 32'(busy), 32'h0);

    // sticky overflow flag
    nxt(); force_ovf = 1'b1; smp();
    chk("ovf_before", 32'(err_overflow), 32'h0);
    nxt(); force_ovf = 1'b0; smp();
    chk("ovf_set", 32'(err_overflow), 32'h1);
    nxt(); nxt(); nxt(); smp();
    chk("ovf_sticky", 32'(err_overflow), 32'h1);
    nxt(); rst = 1'b1;
    nxt(); rst = 1'b0; smp();
    chk("ovf_cleared", 32'(err_overflow), 32'h0);

`ifdef FIFO_ARB_BURST_EN
    // burst ownership, MAX_BURST = 4
    req = 4'b0011;
    nxt();
    for (int k = 0; k < 8; k++) begin
      smp();
      chk("burst_gnt", 32'(gnt), (k < 4) ? 32'h1 : 32'h2);
      nxt();
    end
    rst = 1'b1; req = 4'b0000;
    nxt(); rst = 1'b0; req = 4'b0011;
    nxt(); smp();
    chk("burst_drop_g0a", 32'(gnt), 32'h1);
    nxt(); smp();
    chk("burst_drop_g0b", 32'(gnt), 32'h1);
    nxt(); req = 4'b0010; smp();
    chk("burst_drop_switch", 32'(gnt), 32'h2);
`endif

    nxt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
